// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M multiply/divide unit with busy/done handshake
module muldiv_iter #(
  parameter int XLEN             = 32,
  parameter bit FAST_DIV_SPECIAL = 1'b1
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);

  localparam int DW = 2 * XLEN;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            div_zero_q, div_zero_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] a_mag_q, a_mag_d;
  logic [XLEN-1:0] b_mag_q, b_mag_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [DW-1:0]   acc_q, acc_d;

  logic            a_signed, b_signed;
  logic            in_div_zero, in_ovf;
  logic [XLEN-1:0] in_a_mag, in_b_mag;

  logic [XLEN:0]   rem_sh, rem_diff;
  logic [DW-1:0]   mul_addend, acc_iter;

  logic [DW-1:0]   prod_signed;
  logic [XLEN-1:0] quo_fix, rem_fix, result_fix;

  // Decode operand signedness and magnitudes straight from the request inputs
  always_comb begin
    a_signed    = (iFunct3 == 3'b001) || (iFunct3 == 3'b010) ||
                  (iFunct3 == 3'b100) || (iFunct3 == 3'b110);
    b_signed    = (iFunct3 == 3'b001) || (iFunct3 == 3'b100) || (iFunct3 == 3'b110);
    in_a_mag    = (a_signed && iA[XLEN-1]) ? -iA : iA;
    in_b_mag    = (b_signed && iB[XLEN-1]) ? -iB : iB;
    in_div_zero = iFunct3[2] && (iB == '0);
    in_ovf      = iFunct3[2] && !iFunct3[0] && (iA == MIN_NEG) && (iB == '1);
  end

  // One iteration: shift-add for multiply, one restoring-division quotient bit for divide.
  // For divide the accumulator holds {partial remainder, quotient so far}; dividend bits
  // are taken from the held magnitude, MSB first.
  always_comb begin
    mul_addend = b_mag_q[cnt_q] ? ({{XLEN{1'b0}}, a_mag_q} << cnt_q) : '0;
    rem_sh     = {acc_q[DW-1:XLEN], a_mag_q[LAST - cnt_q]};
    rem_diff   = rem_sh - {1'b0, b_mag_q};
    if (!funct3_q[2]) begin
      acc_iter = acc_q + mul_addend;
    end else if (!rem_diff[XLEN]) begin
      acc_iter = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_iter = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and result selection; divide special cases override the datapath
  always_comb begin
    prod_signed = (sign_a_q ^ sign_b_q) ? -acc_iter : acc_iter;
    quo_fix     = (sign_a_q ^ sign_b_q) ? -acc_iter[XLEN-1:0] : acc_iter[XLEN-1:0];
    rem_fix     = sign_a_q ? -acc_iter[DW-1:XLEN] : acc_iter[DW-1:XLEN];
    result_fix  = '0;
    case (funct3_q)
      3'b000:                 result_fix = acc_iter[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_fix = prod_signed[DW-1:XLEN];
      3'b100, 3'b101: begin
        if (div_zero_q)      result_fix = '1;
        else if (ovf_q)      result_fix = MIN_NEG;
        else                 result_fix = quo_fix;
      end
      default: begin
        if (div_zero_q)      result_fix = sign_a_q ? -a_mag_q : a_mag_q;
        else if (ovf_q)      result_fix = '0;
        else                 result_fix = rem_fix;
      end
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    funct3_d   = funct3_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    acc_d      = acc_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          funct3_d   = iFunct3;
          sign_a_d   = a_signed && iA[XLEN-1];
          sign_b_d   = b_signed && iB[XLEN-1];
          div_zero_d = in_div_zero;
          ovf_d      = in_ovf;
          a_mag_d    = in_a_mag;
          b_mag_d    = in_b_mag;
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        if (FAST_DIV_SPECIAL && (div_zero_q || ovf_q)) begin
          result_d = result_fix;
          state_d  = S_DONE;
        end else begin
          acc_d = acc_iter;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            result_d = result_fix;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      funct3_q   <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      acc_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      funct3_q   <= funct3_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
    end
  end

  assign oBusy   = (state_q != S_IDLE);
  assign oDone   = (state_q == S_DONE);
  assign oResult = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - self-checking bench for muldiv_iter
module tb_muldiv_iter;

  logic        clk;
  logic        rst;
  logic        start_f, start_s;
  logic [2:0]  f3;
  logic [31:0] a, b;
  logic        busy_f, done_f, busy_s, done_s;
  logic [31:0] res_f, res_s;

  int checks = 0;
  int errors = 0;

  muldiv_iter #(.XLEN(32), .FAST_DIV_SPECIAL(1'b1)) dut_fast (
    .iCLK(clk), .iRST(rst), .iStart(start_f), .iFunct3(f3), .iA(a), .iB(b),
    .oBusy(busy_f), .oDone(done_f), .oResult(res_f)
  );

  muldiv_iter #(.XLEN(32), .FAST_DIV_SPECIAL(1'b0)) dut_slow (
    .iCLK(clk), .iRST(rst), .iStart(start_s), .iFunct3(f3), .iA(a), .iB(b),
    .oBusy(busy_s), .oDone(done_s), .oResult(res_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural reference: RV32M arithmetic with wide integers
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    int          ix, iy;
    longint      sx, sy, uy;
    logic [63:0] p;
    ix = x;
    iy = y;
    sx = ix;
    sy = iy;
    uy = longint'({32'b0, y});
    case (f)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        return ix / iy;
      end
      3'd5: begin
        if (y == 0) return 32'hFFFFFFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        return ix % iy;
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input bit slow);
    bit special;
    special = f[2] && ((y == 0) || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
    return (special && !slow) ? 2 : 33;
  endfunction

  // Issue one operation; lat counts the acceptance cycle as 1, -1 if no completion seen
  task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input bit slow, output logic [31:0] res, output int lat);
    res = '0;
    lat = -1;
    @(negedge clk);
    f3 = f; a = x; b = y;
    if (slow) start_s = 1'b1; else start_f = 1'b1;
    @(negedge clk);
    start_s = 1'b0; start_f = 1'b0;
    f3 = 3'($urandom); a = $urandom; b = $urandom;
    for (int k = 0; k < 40; k++) begin
      if (slow ? done_s : done_f) begin
        lat = k + 1;
        res = slow ? res_s : res_f;
        break;
      end
      @(negedge clk);
    end
  endtask

  logic [31:0] r, held;
  int          lat, ndone, last_t;
  int          dts[$];

  initial begin
    rst = 1'b0; start_f = 1'b0; start_s = 1'b0; f3 = '0; a = '0; b = '0;
    vecs[0]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[1]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
    vecs[2]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{3'd0, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 33};
    vecs[5]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vecs[6]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vecs[7]  = '{3'd5, 32'h80000000, 32'h00000003, 32'h2AAAAAAA, 33};
    vecs[8]  = '{3'd7, 32'h80000000, 32'h00000003, 32'h00000002, 33};
    vecs[9]  = '{3'd4, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 2};
    vecs[10] = '{3'd4, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 2};
    vecs[11] = '{3'd7, 32'h00001234, 32'h00000000, 32'h00001234, 2};
    vecs[12] = '{3'd6, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 2};
    vecs[13] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    vecs[14] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2};
    vecs[15] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[16] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33};

    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy_f}, 32'd0);
    check("reset_done", {31'b0, done_f}, 32'd0);
    check("reset_result", res_f, 32'd0);
    rst = 1'b1;

    // Directed table on both instances
    foreach (vecs[i]) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, 1'b0, r, lat);
      check($sformatf("vec%0d_fast_res", i), r, vecs[i].exp);
      check($sformatf("vec%0d_fast_lat", i), 32'(lat), 32'(vecs[i].lat));
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, 1'b1, r, lat);
      check($sformatf("vec%0d_slow_res", i), r, vecs[i].exp);
      check($sformatf("vec%0d_slow_lat", i), 32'(lat), 32'd33);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      bit          slow;
      rf = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 0) rb = 32'h0;
      if (i % 11 == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if (i % 5 == 0) rb = rb >> $urandom_range(31, 0);
      slow = (i % 4 == 0);
      do_op(rf, ra, rb, slow, r, lat);
      check($sformatf("rand%0d_f%0d_res", i, rf), r, ref_op(rf, ra, rb));
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'(ref_lat(rf, ra, rb, slow)));
    end

    // Start pulses during CALC and in the DONE cycle are ignored
    @(negedge clk);
    f3 = 3'd5; a = 32'd100; b = 32'd7; start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    ndone = 0;
    held = 32'h0;
    for (int k = 0; k < 46; k++) begin
      if (done_f) begin ndone++; held = res_f; end
      start_f = (k == 5 || k == 32);
      @(negedge clk);
    end
    start_f = 1'b0;
    check("busy_start_ndone", 32'(ndone), 32'd1);
    check("busy_start_res", held, 32'd14);
    check("busy_start_idle", {31'b0, busy_f}, 32'd0);
    check("busy_start_hold", res_f, 32'd14);

    // Continuous start: one completion every 34 cycles
    @(negedge clk);
    f3 = 3'd0; a = 32'd3; b = 32'd5; start_f = 1'b1;
    last_t = -1;
    for (int t = 0; t < 120; t++) begin
      @(negedge clk);
      if (done_f) begin
        if (last_t >= 0) dts.push_back(t - last_t);
        last_t = t;
      end
    end
    start_f = 1'b0;
    check("hold_ncompl", 32'(dts.size()), 32'd2);
    foreach (dts[i]) check($sformatf("hold_period%0d", i), 32'(dts[i]), 32'd34);
    for (int k = 0; k < 40 && busy_f; k++) @(negedge clk);
    check("hold_drain", {31'b0, busy_f}, 32'd0);

    // Reset mid-operation aborts without a completion
    @(negedge clk);
    f3 = 3'd5; a = 32'd1000; b = 32'd3; start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    ndone = 0;
    for (int k = 0; k < 9; k++) begin
      if (done_f) ndone++;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy_f}, 32'd0);
    check("rst_result", res_f, 32'd0);
    check("rst_done", {31'b0, done_f}, 32'd0);
    check("rst_no_done", 32'(ndone), 32'd0);
    rst = 1'b1;
    do_op(3'd0, 32'd3, 32'd5, 1'b0, r, lat);
    check("post_rst_mul", r, 32'h0000000F);
    check("post_rst_lat", 32'(lat), 32'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative RV32M multiply/divide unit beside the integer ALU in the execute stage of the RISC-V core.
- Consumes the register-file operands (rs1/rs2 read data) plus funct3, and produces a 32-bit result for the writeback mux.
- Drives a busy/done handshake that the control unit uses to freeze PC and register write until the result is ready.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- FAST_DIV_SPECIAL, 1, when 1 divide-by-zero and signed overflow complete in 1 iteration cycle instead of 32.

Ports:
- iCLK  input  1  core clock; all state changes on rising edge.
- iRST  input  1  synchronous, active-low reset.
- iStart  input  1  request; sampled only in IDLE.
- iFunct3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- iA  input  32  rs1 operand (multiplicand / dividend).
- iB  input  32  rs2 operand (multiplier / divisor).
- oBusy  output  1  high while an operation is in flight (CALC or DONE state).
- oDone  output  1  one-cycle pulse; oResult is valid in that cycle.
- oResult  output  32  result; holds its last value until the next completion.

Behaviour:
- Reset (iRST=0 at a rising edge): state IDLE, oBusy=0, oDone=0, oResult=0, counter=0, internal registers cleared. Reset overrides iStart. Reset mid-operation aborts the operation with no oDone pulse.
- States are IDLE, CALC and DONE.
- IDLE to CALC, edge E0:
  - Occurs when iStart=1 at edge E0.
  - Latch iFunct3 and the sign flags.
  - Latch magnitudes |iA| and |iB| for signed operands, per op: MULH and DIV/REM treat both operands as signed; MULHSU treats only A as signed; the rest are unsigned.
  - Clear the 64-bit accumulator / partial remainder; counter=0.
- CALC, one iteration per cycle, counter increments 0..31:
  - Multiply: shift-add over 32 bits of the multiplier, producing a 64-bit unsigned product.
  - Divide: restoring division, one quotient bit per cycle, producing a 32-bit quotient and a 32-bit remainder.
  - The edge at which counter==31 completes the last iteration and moves to DONE, which is edge E0+32.
- DONE (one cycle):
  - Sign fix-up is applied combinationally before the register.
  - oResult is registered and oDone=1 for exactly this cycle.
  - The next edge returns to IDLE.
- Latency: iStart accepted at E0, so oDone is high in the cycle following edge E0+32. Total is 33 cycles from acceptance to result.
- oBusy is 1 from the cycle after E0 through the DONE cycle inclusive, and 0 in IDLE.
- Result selection:
  - MUL: product[31:0].
  - MULH, MULHSU, MULHU: product[63:32], after a 64-bit negate when the product sign is negative.
- Division signs:
  - The quotient is negative iff the operand signs differ.
  - The remainder takes the sign of the dividend.
- Division special cases:
  - Divisor zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = iA.
  - Signed overflow (iA=0x80000000, iB=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
  - With FAST_DIV_SPECIAL=1 these skip CALC: IDLE to DONE at E0+1, so oDone falls in the cycle after E0+1. With FAST_DIV_SPECIAL=0 they run the full 32 cycles and must give the same values.
- iStart while oBusy=1 is ignored, with no queueing. iStart in the DONE cycle is ignored as well. Back-to-back operations start in IDLE, the cycle after the DONE cycle.
- Inputs iA, iB and iFunct3 may change after acceptance without affecting the result.
- oDone never asserts without a preceding accepted start.

Test Plan:
- MULHU directed operands:
  - Reset, then MULHU with iA=0xFFFFFFFF, iB=0xFFFFFFFF gives oResult=0xFFFFFFFE with oDone exactly 33 cycles after acceptance.
  - MUL with the same operands gives 0x00000001.
- Signed multiply:
  - MULH with iA=0xFFFFFFFE (-2), iB=0x00000003 gives 0xFFFFFFFF.
  - MULHSU with iA=0xFFFFFFFF, iB=0xFFFFFFFF gives 0xFFFFFFFF.
  - MUL with iA=-7, iB=6 gives 0xFFFFFFD6.
- Signed division:
  - DIV with -7/2 gives 0xFFFFFFFD.
  - REM with -7/2 gives 0xFFFFFFFF.
  - DIVU with 0x80000000/3 gives 0x2AAAAAAA.
  - REMU with the same operands gives 0x00000002.
- Special cases:
  - DIV with iB=0 gives 0xFFFFFFFF.
  - REMU with iA=0x1234, iB=0 gives 0x00001234.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000, and REM with the same operands gives 0.
  - With FAST_DIV_SPECIAL=1, oDone follows 2 cycles after the start edge; with 0 it follows 33 cycles after.
- Handshake:
  - Pulse iStart again at cycles 5 and 32 of a busy operation; neither is accepted.
  - Exactly one oDone results, and oResult is unchanged until the next accepted start.
  - Holding iStart high continuously yields a completion every 34 cycles.
- Reset mid-operation:
  - Drive iRST=0 at cycle 10 of a DIVU: oBusy=0 and oResult=0 on the next cycle, and no oDone.
  - A fresh MUL 3×5 then returns 0x0000000F.
